cacheline_adaptor: RTL and testbench
====================================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter LINE_W, default 256, the cache line width in bits.
REQ-002 SHALL have parameter BURST_W, default 64, the memory burst width in bits.
REQ-003 SHALL have parameter NUM_BURSTS, default LINE_W/BURST_W (4), the number of bursts per line.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port line_i, input, LINE_W bits: the write-back line from the cache datapath.
REQ-007 SHALL have port line_o, output, LINE_W bits: the fill line to the cache datapath.
REQ-008 SHALL have port address_i, input, 32 bits: the line address from the cache.
REQ-009 SHALL have port read_i, input, 1 bit: the cache line read request.
REQ-010 SHALL have port write_i, input, 1 bit: the cache line write request.
REQ-011 SHALL have port resp_o, output, 1 bit: a one-cycle completion pulse to the cache.
REQ-012 SHALL have port burst_i, input, BURST_W bits: read data from memory.
REQ-013 SHALL have port burst_o, output, BURST_W bits: write data to memory.
REQ-014 SHALL have port address_o, output, 32 bits: the address to memory.
REQ-015 SHALL have port read_o, output, 1 bit: the memory read request.
REQ-016 SHALL have port write_o, output, 1 bit: the memory write request.
REQ-017 SHALL have port resp_i, input, 1 bit: memory burst acknowledge, one per burst.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, DONE, using a burst counter cnt of width log2(NUM_BURSTS).
REQ-019 In IDLE, a rising edge with read_i=1 SHALL latch address_i, clear cnt and enter READ; read_i takes priority if both requests are high.
REQ-020 In IDLE, a rising edge with write_i=1 and read_i=0 SHALL latch address_i and line_i into an internal buffer, clear cnt and enter WRITE.
REQ-021 address_o SHALL be the registered {address_i[31:5], 5'b0} and SHALL be held stable throughout READ and WRITE.
REQ-022 read_o SHALL be 1 exactly while in READ; write_o SHALL be 1 exactly while in WRITE; both are registered-state decodes.
REQ-023 READ: on each edge with resp_i=1, burst_i SHALL be written to line_o[cnt*BURST_W +: BURST_W] and cnt SHALL increment; resp_i=0 is a stall with no change.
REQ-024 READ: the edge that accepts burst NUM_BURSTS-1 SHALL enter DONE.
REQ-025 WRITE: burst_o SHALL equal buffer[cnt*BURST_W +: BURST_W]; each edge with resp_i=1 SHALL advance cnt; the acknowledge of the last burst SHALL enter DONE.
REQ-026 DONE SHALL assert resp_o for exactly one cycle and then return to IDLE unconditionally; requests are not sampled in DONE.
REQ-027 Latency with zero-stall memory: request edge T; read_o or write_o high from T+1 through the edge at T+4; resp_o high during cycle T+5; minimum spacing between back-to-back transactions is 6 cycles.
REQ-028 line_o SHALL hold its value from the end of a read until the next read overwrites it; writes SHALL NOT modify line_o.
REQ-029 resp_i in IDLE or DONE SHALL be ignored; cnt wraps only via the explicit clear on entry.
REQ-030 Changes to line_i or address_i during a transaction SHALL NOT affect burst_o or address_o.

Reset
REQ-031 rst=0 SHALL immediately force state=IDLE, cnt=0, line_o=0, buffer=0, address_o=0, burst_o=0, and read_o=write_o=resp_o=0, including mid-burst (the transaction is aborted).
REQ-032 The first request SHALL be sampled on the first rising edge after rst returns to 1.

Structure
REQ-033 LINE_W, BURST_W and NUM_BURSTS defaults, plus the FSM state enum, SHALL reside in the shared cache types package.
REQ-034 The block SHALL be a single module with no sub-modules; the counter and buffer are inline.

Verification
REQ-035 Read, zero stall: address_i=0x1234_567F, burst_i=0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x1234_5660; line_o = {0x44..,0x33..,0x22..,0x11..}; resp_o high in cycle T+5 only.
REQ-036 Write with stalls: line_i=0xDEAD...BEEF, resp_i pattern 1,0,0,1,1,0,1 -> burst_o steps through slices 0..3, holding during stalls; write_o drops after the 4th acknowledge; line_o unchanged.
REQ-037 Simultaneous read_i=write_i=1 in IDLE -> read_o=1, write_o=0, and the buffer is not loaded.
REQ-038 Assert rst=0 after 2 read bursts -> outputs zero in the same cycle; after release, a new read completes normally with cnt starting at 0.
REQ-039 resp_i=1 while IDLE, and line_i/address_i toggled mid-write -> no state change in IDLE; burst_o/address_o keep their latched values.
REQ-040 Back-to-back: read_i held high across DONE -> the second transaction starts at the edge after DONE; resp_o pulses 6 cycles apart.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: shared cache line/burst geometry and adaptor FSM states
package cacheline_adaptor_pkg;
  localparam int LINE_W_DEF = 256;
  localparam int BURST_W_DEF = 64;
  localparam int NUM_BURSTS_DEF = LINE_W_DEF / BURST_W_DEF;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: converts cache line read/write requests into memory bursts
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int NUM_BURSTS = LINE_W / BURST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);
  localparam int CNT_W = NUM_BURSTS > 1 ? $clog2(NUM_BURSTS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BURSTS - 1);
  state_e state;
  logic [CNT_W-1:0] cnt;
  logic [LINE_W-1:0] buffer;
  logic last;
  assign last = cnt == LAST;
  assign read_o = state == READ;
  assign write_o = state == WRITE;
  assign resp_o = state == DONE;
  // write data is always the buffered line slice selected by the burst counter
  assign burst_o = buffer[cnt*BURST_W +: BURST_W];
  // request capture, burst sequencing and fill-line assembly; counter holds on the last burst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      line_o <= '0;
      buffer <= '0;
      address_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_i) begin
            address_o <= address_i & ~32'h1F;
            cnt <= '0;
            state <= READ;
          end else if (write_i) begin
            address_o <= address_i & ~32'h1F;
            buffer <= line_i;
            cnt <= '0;
            state <= WRITE;
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[cnt*BURST_W +: BURST_W] <= burst_i;
            cnt <= last ? cnt : cnt + CNT_W'(1);
            state <= last ? DONE : READ;
          end
        end
        WRITE: begin
          if (resp_i) begin
            cnt <= last ? cnt : cnt + CNT_W'(1);
            state <= last ? DONE : WRITE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: scoreboard-driven checks of read/write bursts, reset and sequencing
module tb_cacheline_adaptor;
  logic clk = 0;
  logic rst = 0;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic [31:0] address_i = '0;
  logic read_i = 0;
  logic write_i = 0;
  logic resp_o;
  logic [63:0] burst_i = '0;
  logic [63:0] burst_o;
  logic [31:0] address_o;
  logic read_o;
  logic write_o;
  logic resp_i = 0;
  int checks = 0;
  int failures = 0;
  logic [255:0] exp_line_q[$];
  logic [63:0] exp_burst_q[$];
  logic [255:0] last_line = '0;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o), .address_i(address_i),
    .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .burst_i(burst_i),
    .burst_o(burst_o), .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 0;
    step;
    step;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl rd/wr/resp=%b expected 000", {read_o, write_o, resp_o});
    end
    checks++;
    if (line_o !== '0 || burst_o !== '0 || address_o !== '0) begin
      failures++;
      $display("FAIL reset_data line_o=%h burst_o=%h address_o=%h expected all zero", line_o, burst_o, address_o);
    end
    rst = 1;
    step;
    step;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle rd/wr/resp=%b expected 000", {read_o, write_o, resp_o});
    end
  endtask

  task automatic test_read;
    logic [63:0] b [4];
    logic [255:0] exp;
    int seen;
    b = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    last_line = {b[3], b[2], b[1], b[0]};
    exp_line_q.push_back(last_line);
    address_i = 32'h1234_567F;
    read_i = 1;
    resp_i = 1;
    burst_i = b[0];
    step;
    read_i = 0;
    address_i = 32'h0;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b100) begin
      failures++;
      $display("FAIL read_start rd/wr/resp=%b expected 100", {read_o, write_o, resp_o});
    end
    checks++;
    if (address_o !== 32'h1234_5660) begin
      failures++;
      $display("FAIL read_addr address_o=%h expected 12345660", address_o);
    end
    seen = -1;
    for (int n = 1; n <= 12; n++) begin
      step;
      if (resp_o) begin
        seen = n;
        break;
      end
      checks++;
      if (read_o !== 1'b1 || address_o !== 32'h1234_5660) begin
        failures++;
        $display("FAIL read_hold cycle %0d read_o=%b address_o=%h expected 1/12345660", n, read_o, address_o);
      end
      burst_i = b[n < 4 ? n : 3];
    end
    exp = exp_line_q.pop_front();
    checks++;
    if (seen != 4 || read_o !== 1'b0 || line_o !== exp) begin
      failures++;
      $display("FAIL read_done resp at edge %0d read_o=%b line_o=%h expected edge 4 read_o=0 line %h", seen, read_o, line_o, exp);
    end
    step;
    resp_i = 0;
    checks++;
    if (resp_o !== 1'b0) begin
      failures++;
      $display("FAIL read_resp_pulse resp_o=%b expected 0", resp_o);
    end
  endtask

  task automatic test_write_stall;
    logic [255:0] l;
    int pat [7];
    l = 256'hDEADBEEF_01234567_89ABCDEF_CAFEF00D_0BADC0DE_12345678_FEEDFACE_DEADBEEF;
    pat = '{1, 0, 0, 1, 1, 0, 1};
    for (int k = 0; k < 4; k++) exp_burst_q.push_back(l[k*64 +: 64]);
    line_i = l;
    address_i = 32'hABCD_0040;
    write_i = 1;
    resp_i = 0;
    step;
    write_i = 0;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b010 || address_o !== 32'hABCD_0040) begin
      failures++;
      $display("FAIL write_start rd/wr/resp=%b address_o=%h expected 010/abcd0040", {read_o, write_o, resp_o}, address_o);
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (write_o !== 1'b1 || burst_o !== exp_burst_q[0]) begin
        failures++;
        $display("FAIL write_burst step %0d write_o=%b burst_o=%h expected 1/%h", k, write_o, burst_o, exp_burst_q[0]);
      end
      resp_i = pat[k][0];
      step;
      if (pat[k] != 0) void'(exp_burst_q.pop_front());
    end
    resp_i = 0;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b001) begin
      failures++;
      $display("FAIL write_done rd/wr/resp=%b expected 001", {read_o, write_o, resp_o});
    end
    checks++;
    if (line_o !== last_line) begin
      failures++;
      $display("FAIL write_line_o line_o=%h expected %h", line_o, last_line);
    end
    step;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      failures++;
      $display("FAIL write_idle rd/wr/resp=%b expected 000", {read_o, write_o, resp_o});
    end
  endtask

  task automatic test_simultaneous;
    logic [63:0] b [4];
    logic [255:0] exp;
    logic [255:0] w_line;
    int seen;
    w_line = 256'hDEADBEEF_01234567_89ABCDEF_CAFEF00D_0BADC0DE_12345678_FEEDFACE_DEADBEEF;
    b = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5A5A_A5A5_0F0F_F0F0, 64'h8000_0000_0000_0001};
    last_line = {b[3], b[2], b[1], b[0]};
    exp_line_q.push_back(last_line);
    line_i = ~w_line;
    address_i = 32'h0000_0100;
    read_i = 1;
    write_i = 1;
    resp_i = 1;
    burst_i = b[0];
    step;
    read_i = 0;
    write_i = 0;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b100 || address_o !== 32'h0000_0100) begin
      failures++;
      $display("FAIL both_req rd/wr/resp=%b address_o=%h expected 100/00000100", {read_o, write_o, resp_o}, address_o);
    end
    checks++;
    if (burst_o !== w_line[63:0]) begin
      failures++;
      $display("FAIL both_req_buffer burst_o=%h expected %h", burst_o, w_line[63:0]);
    end
    seen = -1;
    for (int n = 1; n <= 12; n++) begin
      step;
      if (resp_o) begin
        seen = n;
        break;
      end
      burst_i = b[n < 4 ? n : 3];
    end
    exp = exp_line_q.pop_front();
    checks++;
    if (seen != 4 || line_o !== exp) begin
      failures++;
      $display("FAIL both_req_read resp at edge %0d line_o=%h expected edge 4 line %h", seen, line_o, exp);
    end
    resp_i = 0;
    step;
  endtask

  task automatic test_reset_mid;
    logic [63:0] c [4];
    logic [255:0] exp;
    int seen;
    address_i = 32'h0000_2000;
    read_i = 1;
    resp_i = 1;
    burst_i = 64'hAAAA_0000_0000_0001;
    step;
    read_i = 0;
    step;
    burst_i = 64'hAAAA_0000_0000_0002;
    step;
    checks++;
    if (read_o !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre read_o=%b expected 1", read_o);
    end
    rst = 0;
    #1;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      failures++;
      $display("FAIL abort_ctrl rd/wr/resp=%b expected 000", {read_o, write_o, resp_o});
    end
    checks++;
    if (line_o !== '0 || address_o !== '0 || burst_o !== '0) begin
      failures++;
      $display("FAIL abort_data line_o=%h address_o=%h burst_o=%h expected all zero", line_o, address_o, burst_o);
    end
    step;
    rst = 1;
    c = '{64'hC0C0_0000_0000_0000, 64'hC1C1_1111_0000_0000, 64'hC2C2_2222_2222_0000, 64'hC3C3_3333_3333_3333};
    last_line = {c[3], c[2], c[1], c[0]};
    exp_line_q.push_back(last_line);
    address_i = 32'h0000_3000;
    read_i = 1;
    burst_i = c[0];
    step;
    read_i = 0;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b100 || address_o !== 32'h0000_3000) begin
      failures++;
      $display("FAIL post_reset_start rd/wr/resp=%b address_o=%h expected 100/00003000", {read_o, write_o, resp_o}, address_o);
    end
    seen = -1;
    for (int n = 1; n <= 12; n++) begin
      step;
      if (resp_o) begin
        seen = n;
        break;
      end
      burst_i = c[n < 4 ? n : 3];
    end
    exp = exp_line_q.pop_front();
    checks++;
    if (seen != 4 || line_o !== exp) begin
      failures++;
      $display("FAIL post_reset_read resp at edge %0d line_o=%h expected edge 4 line %h", seen, line_o, exp);
    end
    resp_i = 0;
    step;
  endtask

  task automatic test_idle_resp_toggle;
    logic [255:0] l2;
    resp_i = 1;
    for (int k = 0; k < 3; k++) begin
      step;
      checks++;
      if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== last_line) begin
        failures++;
        $display("FAIL idle_resp rd/wr/resp=%b line_o=%h expected 000/%h", {read_o, write_o, resp_o}, line_o, last_line);
      end
    end
    resp_i = 0;
    l2 = {64'hD4D4_D4D4_0000_0004, 64'hC3C3_C3C3_0000_0003, 64'hB2B2_B2B2_0000_0002, 64'hA1A1_A1A1_0000_0001};
    for (int k = 0; k < 4; k++) exp_burst_q.push_back(l2[k*64 +: 64]);
    line_i = l2;
    address_i = 32'h5555_5555;
    write_i = 1;
    step;
    write_i = 0;
    for (int k = 0; k < 4; k++) begin
      line_i = {8{$urandom()}};
      address_i = $urandom();
      checks++;
      if (write_o !== 1'b1 || address_o !== 32'h5555_5540 || burst_o !== exp_burst_q[0]) begin
        failures++;
        $display("FAIL toggle_write step %0d write_o=%b address_o=%h burst_o=%h expected 1/55555540/%h", k, write_o, address_o, burst_o, exp_burst_q[0]);
      end
      resp_i = 1;
      step;
      void'(exp_burst_q.pop_front());
    end
    resp_i = 0;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b001 || line_o !== last_line) begin
      failures++;
      $display("FAIL toggle_done rd/wr/resp=%b line_o=%h expected 001/%h", {read_o, write_o, resp_o}, line_o, last_line);
    end
    step;
  endtask

  task automatic test_back_to_back;
    logic [255:0] exp;
    int t [2];
    int nresp;
    t = '{-1, -1};
    nresp = 0;
    exp_line_q.push_back({{8{8'd4}}, {8{8'd3}}, {8{8'd2}}, {8{8'd1}}});
    exp_line_q.push_back({{8{8'd10}}, {8{8'd9}}, {8{8'd8}}, {8{8'd7}}});
    address_i = 32'h0000_4000;
    read_i = 1;
    resp_i = 1;
    for (int n = 0; n < 30 && nresp < 2; n++) begin
      step;
      if (resp_o) begin
        exp = exp_line_q.pop_front();
        t[nresp] = n;
        checks++;
        if (line_o !== exp) begin
          failures++;
          $display("FAIL b2b_line %0d line_o=%h expected %h", nresp, line_o, exp);
        end
        nresp++;
        if (nresp == 2) read_i = 0;
      end
      burst_i = {8{8'(n + 1)}};
    end
    checks++;
    if (t[0] != 4 || t[1] - t[0] != 6) begin
      failures++;
      $display("FAIL b2b_spacing resp edges %0d,%0d expected 4,10", t[0], t[1]);
    end
    read_i = 0;
    resp_i = 0;
    step;
    step;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      failures++;
      $display("FAIL b2b_idle rd/wr/resp=%b expected 000", {read_o, write_o, resp_o});
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write_stall;
    test_simultaneous;
    test_reset_mid;
    test_idle_resp_toggle;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
